// File: rtl/line_raster_stream.sv
// line_raster_stream: Bresenham line rasteriser with a valid/ready segment
// input and a valid/ready pixel output stream. All eight octants are handled,
// and both endpoints are emitted.
// Optional feature: define LINE_RASTER_CLIP_EN to suppress pixels outside
// SCREEN_W x SCREEN_H. Suppressed pixels are stepped through at one per cycle.
module line_raster_stream #(
    parameter int COORD_W  = 9,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 180
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [COORD_W-1:0]  x0,
    input  logic [COORD_W-1:0]  y0,
    input  logic [COORD_W-1:0]  x1,
    input  logic [COORD_W-1:0]  y1,
    input  logic [COLOUR_W-1:0] in_colour,
    output logic                px_valid,
    input  logic                px_ready,
    output logic [COORD_W-1:0]  px_x,
    output logic [COORD_W-1:0]  px_y,
    output logic [COLOUR_W-1:0] px_colour,
    output logic                px_last,
    output logic                done
);

    // Deltas and the error term need two extra bits: one for the sign, and one
    // for a magnitude of up to 2^COORD_W - 1. 2*err needs two more bits on top.
    localparam int DW = COORD_W + 2;
    localparam int EW = DW + 2;

    typedef enum logic [1:0] {IDLE, SETUP, STEP} state_t;

    state_t                state_q;
    logic [COORD_W-1:0]    x0_q, y0_q, x1_q, y1_q;
    logic [COORD_W-1:0]    cur_x_q, cur_y_q;
    logic [COLOUR_W-1:0]   colour_q, px_colour_q;
    logic signed [DW-1:0]  dx_q, dy_q, err_q;
    logic                  sx_neg_q, sy_neg_q, at_end_q;
    logic                  in_ready_q, px_valid_q, px_last_q, done_q;

    // Setup-time values that are derived from the latched endpoints.
    logic signed [DW-1:0]  diff_x, diff_y, dx_s, dy_s;
    logic                  start_end;

    // Per-step next-state values.
    logic signed [EW-1:0]  e2, dx_e, dy_e;
    logic                  step_x, step_y;
    logic signed [DW-1:0]  err_d;
    logic [COORD_W-1:0]    cur_x_d, cur_y_d;
    logic                  next_end;

    // Visibility of the start point and of the next point.
    logic                  start_on, next_on;

`ifdef LINE_RASTER_CLIP_EN
    function automatic logic in_screen(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return (32'(x) < 32'(SCREEN_W)) && (32'(y) < 32'(SCREEN_H));
    endfunction

    assign start_on = in_screen(x0_q, y0_q);
    assign next_on  = in_screen(cur_x_d, cur_y_d);
`else
    // Without clipping every pixel is visible, so the screen size has no effect.
    logic unused_screen;
    assign unused_screen = ^{SCREEN_W, SCREEN_H};
    assign start_on = 1'b1;
    assign next_on  = 1'b1;
`endif

    // Compute the absolute deltas and the step directions from the latched endpoints.
    always_comb begin
        diff_x    = $signed({2'b00, x1_q}) - $signed({2'b00, x0_q});
        diff_y    = $signed({2'b00, y1_q}) - $signed({2'b00, y0_q});
        dx_s      = (diff_x < 0) ? -diff_x : diff_x;
        dy_s      = (diff_y < 0) ? diff_y : -diff_y;
        start_end = (x0_q == x1_q) && (y0_q == y1_q);
    end

    // Compute one Bresenham step from the current point and the current error.
    always_comb begin
        e2      = {{2{err_q[DW-1]}}, err_q} <<< 1;
        dx_e    = {{2{dx_q[DW-1]}}, dx_q};
        dy_e    = {{2{dy_q[DW-1]}}, dy_q};
        step_x  = (e2 >= dy_e);
        step_y  = (e2 <= dx_e);
        err_d   = err_q + (step_x ? dy_q : {DW{1'b0}}) + (step_y ? dx_q : {DW{1'b0}});
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (step_x) begin
            cur_x_d = sx_neg_q ? (cur_x_q - 1'b1) : (cur_x_q + 1'b1);
        end
        if (step_y) begin
            cur_y_d = sy_neg_q ? (cur_y_q - 1'b1) : (cur_y_q + 1'b1);
        end
        next_end = (cur_x_d == x1_q) && (cur_y_d == y1_q);
    end

    // Control FSM with registered outputs: accept a segment, set it up, then
    // advance one point per beat. An invisible point advances without waiting.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            px_valid_q  <= 1'b0;
            px_last_q   <= 1'b0;
            done_q      <= 1'b0;
            at_end_q    <= 1'b0;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            colour_q    <= '0;
            px_colour_q <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            err_q       <= '0;
            sx_neg_q    <= 1'b0;
            sy_neg_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        x0_q       <= x0;
                        y0_q       <= y0;
                        x1_q       <= x1;
                        y1_q       <= y1;
                        colour_q   <= in_colour;
                        in_ready_q <= 1'b0;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    dx_q        <= dx_s;
                    dy_q        <= dy_s;
                    err_q       <= dx_s + dy_s;
                    sx_neg_q    <= (x1_q < x0_q);
                    sy_neg_q    <= (y1_q < y0_q);
                    cur_x_q     <= x0_q;
                    cur_y_q     <= y0_q;
                    px_colour_q <= colour_q;
                    at_end_q    <= start_end;
                    px_valid_q  <= start_on;
                    px_last_q   <= start_end && start_on;
                    state_q     <= STEP;
                end
                STEP: begin
                    if (px_ready || !px_valid_q) begin
                        if (at_end_q) begin
                            px_valid_q <= 1'b0;
                            px_last_q  <= 1'b0;
                            done_q     <= 1'b1;
                            in_ready_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            cur_x_q    <= cur_x_d;
                            cur_y_q    <= cur_y_d;
                            err_q      <= err_d;
                            at_end_q   <= next_end;
                            px_valid_q <= next_on;
                            px_last_q  <= next_end && next_on;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                    px_valid_q <= 1'b0;
                    px_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign px_valid  = px_valid_q;
    assign px_x      = cur_x_q;
    assign px_y      = cur_y_q;
    assign px_colour = px_colour_q;
    assign px_last   = px_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_line_raster_stream.sv
// Self-checking bench for line_raster_stream. It uses a table of fixed segments
// with explicit pixel lists, hand-written reset and back-to-back sequences, and
// random segments that are checked against an integer line-walk model.
`timescale 1ns/1ps
module tb_line_raster_stream;
    localparam int CW = 9;
    localparam int LW = 3;

    logic          clock     = 1'b0;
    logic          resetn    = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [CW-1:0] x0        = '0;
    logic [CW-1:0] y0        = '0;
    logic [CW-1:0] x1        = '0;
    logic [CW-1:0] y1        = '0;
    logic [LW-1:0] in_colour = '0;
    logic          px_valid;
    logic          px_ready  = 1'b0;
    logic [CW-1:0] px_x, px_y;
    logic [LW-1:0] px_colour;
    logic          px_last, done;

    line_raster_stream #(
        .COORD_W(CW), .COLOUR_W(LW), .SCREEN_W(320), .SCREEN_H(180)
    ) dut (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .in_colour(in_colour),
        .px_valid(px_valid), .px_ready(px_ready),
        .px_x(px_x), .px_y(px_y), .px_colour(px_colour),
        .px_last(px_last), .done(done)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          last;
    } pix_t;

    typedef struct packed {
        logic [CW-1:0]       x0, y0, x1, y1;
        logic [LW-1:0]       col;
        logic [3:0]          n;
        logic [1:0]          mode;
        logic [0:7][CW-1:0]  px;
        logic [0:7][CW-1:0]  py;
    } vec_t;

    pix_t exp_q[$];
    pix_t p;
    vec_t tv[6];
    int   seg_col;
    bit   clipped;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit on_screen(input int x, input int y);
`ifdef LINE_RASTER_CLIP_EN
        return (x < 320) && (y < 180);
`else
        return (x >= 0) && (y >= 0);
`endif
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference model: walk the line with integer arithmetic and keep the visible points.
    task automatic model(input int ax0, input int ay0, input int ax1, input int ay1);
        int dx, dy, sx, sy, err, e2, x, y;
        pix_t q;
        exp_q.delete();
        clipped = 1'b0;
        dx  = iabs(ax1 - ax0);
        dy  = -iabs(ay1 - ay0);
        sx  = (ax1 >= ax0) ? 1 : -1;
        sy  = (ay1 >= ay0) ? 1 : -1;
        err = dx + dy;
        x   = ax0;
        y   = ay0;
        while (1) begin
            if (on_screen(x, y)) begin
                q.x    = CW'(x);
                q.y    = CW'(y);
                q.last = (x == ax1) && (y == ay1);
                exp_q.push_back(q);
            end else begin
                clipped = 1'b1;
            end
            if (x == ax1 && y == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // Called on a falling edge. Presents one segment, then scrambles the inputs after acceptance.
    task automatic issue(input int ax0, input int ay0, input int ax1, input int ay1, input int acol);
        chk("in_ready_idle", int'(in_ready), 1);
        in_valid  = 1'b1;
        x0        = CW'(ax0);
        y0        = CW'(ay0);
        x1        = CW'(ax1);
        y1        = CW'(ay1);
        in_colour = LW'(acol);
        seg_col   = acol;
        @(negedge clock);
        in_valid  = 1'b0;
        x0        = CW'($urandom_range(0, 511));
        y0        = CW'($urandom_range(0, 511));
        x1        = CW'($urandom_range(0, 511));
        y1        = CW'($urandom_range(0, 511));
        in_colour = LW'($urandom_range(0, 7));
        chk("setup_no_valid", int'(px_valid), 0);
        chk("done_one_cycle", int'(done), 0);
        chk("busy_in_ready", int'(in_ready), 0);
        @(negedge clock);
        if (exp_q.size() > 0 && int'(exp_q[0].x) == ax0 && int'(exp_q[0].y) == ay0)
            chk("first_px_latency", int'(px_valid), 1);
    endtask

    // Consume pixels until done. mode 0: always ready; mode 1: random ready;
    // mode 2: hold ready low for 3 cycles on the third pixel. Returns on the done cycle.
    task automatic collect(input int mode);
        int cyc = 0, beats = 0, first_cyc = -1, last_pop_cyc = -10, stall_cnt = 0;
        int prev_x = 0, prev_y = 0, prev_l = 0;
        bit prev_stall = 1'b0, popped_last = 1'b0, r;
        while (1) begin
            if (cyc >= 3000) begin
                chk("timeout_waiting_done", 0, 1);
                break;
            end
            if (done) begin
                chk("pixels_remaining", exp_q.size(), 0);
                chk("done_in_ready", int'(in_ready), 1);
                chk("done_no_valid", int'(px_valid), 0);
                if (popped_last) chk("done_latency", cyc - last_pop_cyc, 1);
                if (mode == 0 && !clipped && first_cyc >= 0)
                    chk("throughput", cyc - first_cyc, beats);
                break;
            end
            chk("busy_in_ready", int'(in_ready), 0);
            if (px_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (prev_stall) begin
                    chk("stall_hold_x", int'(px_x), prev_x);
                    chk("stall_hold_y", int'(px_y), prev_y);
                    chk("stall_hold_last", int'(px_last), prev_l);
                end
                if (exp_q.size() == 0) begin
                    chk("extra_pixel", 1, 0);
                end else begin
                    chk("px_x", int'(px_x), int'(exp_q[0].x));
                    chk("px_y", int'(px_y), int'(exp_q[0].y));
                    chk("px_last", int'(px_last), int'(exp_q[0].last));
                    chk("px_colour", int'(px_colour), seg_col);
                end
                if (mode == 0) r = 1'b1;
                else if (mode == 1) r = ($urandom_range(0, 3) != 0);
                else if (beats == 2 && stall_cnt < 3) begin r = 1'b0; stall_cnt++; end
                else r = 1'b1;
                px_ready = r;
                if (r) begin
                    if (exp_q.size() > 0) begin
                        popped_last = exp_q[0].last;
                        void'(exp_q.pop_front());
                    end
                    beats++;
                    last_pop_cyc = cyc;
                end
                prev_stall = !r;
                prev_x = int'(px_x);
                prev_y = int'(px_y);
                prev_l = int'(px_last);
            end else begin
                px_ready   = ($urandom_range(0, 1) != 0);
                prev_stall = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
    endtask

    initial begin
        int cnt;
        int ax0, ay0, ax1, ay1;

        tv[0] = {9'd10, 9'd5, 9'd14, 9'd5, 3'd3, 4'd5, 2'd0,
                 {9'd10, 9'd11, 9'd12, 9'd13, 9'd14, 27'd0}, {{5{9'd5}}, 27'd0}};
        tv[1] = {9'd0, 9'd0, 9'd2, 9'd6, 3'd5, 4'd7, 2'd0,
                 {9'd0, 9'd0, 9'd1, 9'd1, 9'd1, 9'd2, 9'd2, 9'd0},
                 {9'd0, 9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd0}};
        tv[2] = {9'd14, 9'd5, 9'd10, 9'd5, 3'd1, 4'd5, 2'd0,
                 {9'd14, 9'd13, 9'd12, 9'd11, 9'd10, 27'd0}, {{5{9'd5}}, 27'd0}};
        tv[3] = {9'd7, 9'd7, 9'd7, 9'd7, 3'd6, 4'd1, 2'd0, {9'd7, 63'd0}, {9'd7, 63'd0}};
        tv[4] = {9'd0, 9'd0, 9'd5, 9'd3, 3'd2, 4'd6, 2'd2,
                 {9'd0, 9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 18'd0},
                 {9'd0, 9'd1, 9'd1, 9'd2, 9'd2, 9'd3, 18'd0}};
        tv[5] = {9'd9, 9'd9, 9'd2, 9'd2, 3'd7, 4'd8, 2'd1,
                 {9'd9, 9'd8, 9'd7, 9'd6, 9'd5, 9'd4, 9'd3, 9'd2},
                 {9'd9, 9'd8, 9'd7, 9'd6, 9'd5, 9'd4, 9'd3, 9'd2}};

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_px_valid", int'(px_valid), 0);
        chk("rst_px_last", int'(px_last), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_px_x", int'(px_x), 0);
        chk("rst_px_y", int'(px_y), 0);
        chk("rst_px_colour", int'(px_colour), 0);
        resetn = 1'b1;
        @(negedge clock);

        // Fixed segments with explicit pixel lists
        for (int i = 0; i < 6; i++) begin
            exp_q.delete();
            clipped = 1'b0;
            for (int k = 0; k < int'(tv[i].n); k++) begin
                p.x    = tv[i].px[k];
                p.y    = tv[i].py[k];
                p.last = (k == int'(tv[i].n) - 1);
                exp_q.push_back(p);
            end
            issue(int'(tv[i].x0), int'(tv[i].y0), int'(tv[i].x1), int'(tv[i].y1), int'(tv[i].col));
            collect(int'(tv[i].mode));
            repeat (2) @(negedge clock);
        end

        // Back-to-back: the second segment is presented in the done cycle
        model(3, 4, 8, 6);
        issue(3, 4, 8, 6, 4);
        collect(0);
        model(8, 6, 1, 2);
        issue(8, 6, 1, 2, 5);
        collect(0);
        repeat (2) @(negedge clock);

        // Reset on the fourth pixel aborts the segment
        model(0, 0, 20, 0);
        issue(0, 0, 20, 0, 4);
        px_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            if (px_valid) cnt++;
            if (cnt == 4) break;
            @(negedge clock);
        end
        chk("abort_reached_4th", cnt, 4);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_px_valid", int'(px_valid), 0);
        chk("abort_done", int'(done), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("abort_no_done", int'(done), 0);
            chk("abort_idle_valid", int'(px_valid), 0);
        end
        exp_q.delete();
        px_ready = 1'b0;

`ifdef LINE_RASTER_CLIP_EN
        // Right-edge clipping: only the on-screen part is emitted, with no px_last
        model(318, 0, 322, 0);
        chk("clip_model_count", exp_q.size(), 2);
        issue(318, 0, 322, 0, 3);
        collect(0);
        repeat (2) @(negedge clock);
`endif

        // Random segments checked against the model
        for (int t = 0; t < 40; t++) begin
            if (t % 4 == 3) begin
                ax0 = $urandom_range(480, 511);
                ay0 = $urandom_range(480, 511);
                ax1 = $urandom_range(480, 511);
                ay1 = $urandom_range(480, 511);
            end else begin
                ax0 = $urandom_range(0, 40);
                ay0 = $urandom_range(0, 40);
                ax1 = $urandom_range(0, 40);
                ay1 = $urandom_range(0, 40);
            end
            model(ax0, ay0, ax1, ay1);
            issue(ax0, ay0, ax1, ay1, $urandom_range(0, 7));
            collect((t % 3 == 0) ? 0 : 1);
            if ($urandom_range(0, 1) != 0) @(negedge clock);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
